// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds one operand bit pair per cycle, LSB first,
// through a one-bit alu slice and assembles a WIDTH-bit result plus flags.
// Ports: clk, rst_n (async active-low); start, a_in, b_in, alu_ctrl (request);
//        busy, done, result, carry_out, zero (status/result);
//        overflow (present only when OVERFLOW_EN is defined).
// Optional feature macro: OVERFLOW_EN.

module alu (
    output logic       res,
    output logic       carry_out,
    input  logic       carry_in,
    input  logic       a,
    input  logic       b,
    input  logic [2:0] aluCont
);
    logic bb;

    assign bb        = b ^ aluCont[2];
    assign carry_out = (a & bb) | (a & carry_in) | (bb & carry_in);

    always_comb begin
        res = 1'b0;
        unique case (aluCont[1:0])
            2'b00: res = a & bb;
            2'b01: res = a | bb;
            2'b10: res = a ^ bb;
            2'b11: res = a ^ bb ^ carry_in;
            default: res = 1'b0;
        endcase
    end
endmodule

module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       alu_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             zero
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [2:0]       ctrl;
    logic             carry;
    logic [IW-1:0]    idx;

    logic             slice_res;
    logic             slice_co;
    logic [WIDTH-1:0] res_next;
    logic             last;
    logic             is_sum;

    alu u_slice (
        .res       (slice_res),
        .carry_out (slice_co),
        .carry_in  (carry),
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .aluCont   (ctrl)
    );

    // Operands are shifted right each cycle, so bit 0 is always A[index].
    assign res_next = {slice_res, res_sh[WIDTH-1:1]};
    assign last     = (idx == IW'(WIDTH - 1));
    assign is_sum   = (ctrl[1:0] == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            ctrl      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
`ifdef OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        ctrl  <= alu_ctrl;
                        carry <= alu_ctrl[2];
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= slice_co;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= res_next;
                        zero      <= (res_next == '0);
                        carry_out <= is_sum & slice_co;
`ifdef OVERFLOW_EN
                        // Signed overflow: carry into MSB differs from carry out.
                        overflow  <= is_sum & (carry ^ slice_co);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq: directed vectors push expectations,
// a monitor pops and compares on every done pulse.

module tb_serial_alu_seq;
    localparam int W = 32;
    localparam int LAT = 33;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         z;
        logic         ov;
        int           cyc;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [2:0]   alu_ctrl;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
`ifdef OVERFLOW_EN
    logic         overflow;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .alu_ctrl  (alu_ctrl),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
`ifdef OVERFLOW_EN
        .overflow  (overflow),
`endif
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [W-1:0] r,
                        input logic co, input logic z, input logic ov,
                        input int dcyc);
        exp_t e;
        e.res = r; e.co = co; e.z = z; e.ov = ov; e.cyc = dcyc; e.name = name;
        sb.push_back(e);
    endtask

    // Wait for busy=0 at a falling edge (bounded), then issue one request.
    task automatic issue(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] c,
                         input logic [W-1:0] r, input logic co,
                         input logic z, input logic ov);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_wait_idle"}, 64'(busy), 64'(0));
        a_in = a; b_in = b; alu_ctrl = c; start = 1'b1;
        push(name, r, co, z, ov, cyc + LAT);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, 64'(result), 64'(e.res));
                    check({e.name, "_carry"}, 64'(carry_out), 64'(e.co));
                    check({e.name, "_zero"}, 64'(zero), 64'(e.z));
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, "_busy"}, 64'(busy), 64'(0));
`ifdef OVERFLOW_EN
                    check({e.name, "_ovf"}, 64'(overflow), 64'(e.ov));
`endif
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0;
        a_in = '0; b_in = '0; alu_ctrl = '0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_carry", 64'(carry_out), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue("add_5_3", 32'h5, 32'h3, 3'b011, 32'h8, 0, 0, 0);
        issue("sub_3_5", 32'h3, 32'h5, 3'b111, 32'hFFFF_FFFE, 0, 0, 0);
        issue("sub_5_5", 32'h5, 32'h5, 3'b111, 32'h0, 1, 1, 0);
        issue("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000,
              32'hF000_F000, 0, 0, 0);
        issue("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001,
              32'hFFF0_FFF0, 0, 0, 0);
        issue("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010,
              32'h0FF0_0FF0, 0, 0, 0);
        issue("add_wrap", 32'hFFFF_FFFF, 32'h1, 3'b011, 32'h0, 1, 1, 0);
        issue("add_ovf", 32'h7FFF_FFFF, 32'h1, 3'b011,
              32'h8000_0000, 0, 0, 1);

        // Start pulse with new operands mid-run must be ignored.
        issue("add_ign", 32'h1234_5678, 32'h1111_1111, 3'b011,
              32'h2345_6789, 0, 0, 0);
        repeat (9) @(negedge clk);
        a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF;
        alu_ctrl = 3'b111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start held high: second op accepted back-to-back in DONE.
        @(negedge clk);
        k = cyc;
        a_in = 32'hAAAA_5555; b_in = 32'h0F0F_0F0F;
        alu_ctrl = 3'b010; start = 1'b1;
        push("b2b_xor", 32'hA5A5_5A5A, 0, 0, 0, k + LAT);
        @(negedge clk);
        a_in = 32'h10; b_in = 32'h1; alu_ctrl = 3'b111;
        push("b2b_sub", 32'hF, 1, 0, 0, k + 2 * LAT);
        while (cyc < k + LAT + 1) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Asynchronous reset mid-run clears outputs immediately.
        issue("add_rst", 32'h1, 32'h2, 3'b011, 32'h3, 0, 0, 0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_result", 64'(result), 64'(0));
        check("mid_rst_carry", 64'(carry_out), 64'(0));
        check("mid_rst_zero", 64'(zero), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue("add_post_rst", 32'h100, 32'h200, 3'b011, 32'h300, 0, 0, 0);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
